// File: rtl/frame_seq_ctrl_if.sv
// Pixel stream bundle for frame_seq_ctrl: upstream source handshake plus the
// write side of the pipeline input FIFO.
//   master : the sequencer (consumes src_*, produces fifo_* writes)
//   slave  : the environment (pixel source + FIFO)
interface frame_seq_ctrl_if;
    logic        src_valid;
    logic [23:0] src_data;
    logic        src_ready;
    logic        fifo_wr_en;
    logic [23:0] fifo_din;
    logic        fifo_full;

    modport master (
        input  src_valid,
        input  src_data,
        input  fifo_full,
        output src_ready,
        output fifo_wr_en,
        output fifo_din
    );

    modport slave (
        output src_valid,
        output src_data,
        output fifo_full,
        input  src_ready,
        input  fifo_wr_en,
        input  fifo_din
    );
endinterface

// File: rtl/frame_seq_ctrl.sv
// frame_seq_ctrl: sequences one video frame through a Sobel pipeline.
// IDLE -> STREAM (feed FRAME_PIXELS pixels into the input FIFO)
//      -> DRAIN  (wait for the pipeline to write FRAME_PIXELS results)
//      -> DONE   (one-cycle done pulse) -> IDLE.
// Pixels pass combinationally from the source to the FIFO write port.
// Optional drain watchdog: define FRAME_SEQ_CTRL_TIMEOUT_EN to enable it.
// Without it, error is tied low and DRAIN waits forever.
module frame_seq_ctrl #(
    parameter int IMG_WIDTH      = 720,
    parameter int IMG_HEIGHT     = 540,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sink_wr_en,
    frame_seq_ctrl_if.master       bus,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [19:0]            in_count,
    output logic [19:0]            out_count
);

    localparam logic [19:0] FRAME_PIXELS = 20'(IMG_WIDTH * IMG_HEIGHT);

    // Counters are 20 bits wide, so the frame has to fit.
    if ((IMG_WIDTH * IMG_HEIGHT) >= (1 << 20) || IMG_WIDTH < 1 || IMG_HEIGHT < 1
        || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("frame_seq_ctrl: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [19:0] in_count_q, in_count_d;
    logic [19:0] out_count_q, out_count_d;

    logic        ready_int;   // source may transfer this cycle
    logic        xfer;        // pixel moves source -> FIFO this cycle
    logic        start_acc;   // start accepted (only meaningful in IDLE)
    logic        sink_acc;    // pipeline output strobe that counts
    logic        out_full;    // all results of the frame written
    logic        tmo;         // drain watchdog expired this cycle

    assign ready_int = (state_q == S_STREAM) && !bus.fifo_full;
    assign xfer      = bus.src_valid && ready_int;
    assign start_acc = (state_q == S_IDLE) && start;
    assign out_full  = (out_count_q == FRAME_PIXELS);
    assign sink_acc  = sink_wr_en && !out_full
                       && ((state_q == S_STREAM) || (state_q == S_DRAIN));

`ifdef FRAME_SEQ_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            error_q, error_d;

    // Expire on the TIMEOUT_CYCLES-th consecutive silent DRAIN cycle; a
    // frame that has already completed never times out.
    assign tmo = (state_q == S_DRAIN) && !sink_wr_en && !out_full
                 && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts silent DRAIN cycles, restarting on every sink strobe.
    always_comb begin
        wd_d = wd_q;
        if (state_q != S_DRAIN || sink_wr_en) begin
            wd_d = '0;
        end else if (!tmo) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    // Error is sticky until the next accepted start.
    always_comb begin
        error_d = error_q;
        if (start_acc) begin
            error_d = 1'b0;
        end else if (tmo) begin
            error_d = 1'b1;
        end
    end

    // Watchdog and error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign tmo   = 1'b0;
    assign error = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                // Last pixel of the frame closes the input side; even if all
                // results are already in, DRAIN is visited for one cycle.
                if (xfer && (in_count_q == FRAME_PIXELS - 20'd1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_full || tmo) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state plus the pass-through path.
    always_comb begin
        busy           = (state_q == S_STREAM) || (state_q == S_DRAIN);
        done           = (state_q == S_DONE);
        bus.src_ready  = ready_int;
        bus.fifo_wr_en = xfer;
        bus.fifo_din   = bus.src_data;
    end

    // Frame counters: cleared by an accepted start, then count transfers
    // and (saturating) pipeline output strobes independently.
    always_comb begin
        in_count_d  = in_count_q;
        out_count_d = out_count_q;
        if (start_acc) begin
            in_count_d  = '0;
            out_count_d = '0;
        end else begin
            if (xfer) begin
                in_count_d = in_count_q + 20'd1;
            end
            if (sink_acc) begin
                out_count_d = out_count_q + 20'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_count_q  <= '0;
            out_count_q <= '0;
        end else begin
            in_count_q  <= in_count_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_count  = in_count_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Scoreboard bench for frame_seq_ctrl with a 4x3 frame and 16-cycle watchdog.
// Stimulus pushes the expected FIFO data and done records; a monitor pops and
// compares on every fifo_wr_en / done it observes.
module tb_frame_seq_ctrl;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int FP = 12;
    localparam int TO = 16;

    typedef struct packed {
        logic [19:0] ic;
        logic [19:0] oc;
        logic        err;
    } done_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sink_wr_en;
    logic        busy, done, error;
    logic [19:0] in_count, out_count;

    frame_seq_ctrl_if bus ();

    frame_seq_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sink_wr_en (sink_wr_en),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .in_count   (in_count),
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    logic [23:0] exp_data[$];
    done_t       exp_done[$];
    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int idx      = 0;
    int tag      = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_evt(input string nm, input string info);
        checks++;
        failures++;
        $display("FAIL %s: %s", nm, info);
    endtask

    function automatic logic [23:0] pix(input int f, input int i);
        return {f[7:0], 8'h5A, i[7:0]};
    endfunction

    // Monitor: samples settled outputs 2ns after the falling edge.
    initial begin
        done_t d;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (bus.fifo_wr_en) begin
                    chk("wr_gate_full", {31'b0, bus.fifo_full}, 32'd0);
                    if (exp_data.size() == 0)
                        fail_evt("unexpected_write", $sformatf("din=%0h", bus.fifo_din));
                    else
                        chk("fifo_din", bus.fifo_din, exp_data.pop_front());
                end
                if (bus.fifo_full) chk("ready_when_full", {31'b0, bus.src_ready}, 32'd0);
                if (!busy) chk("ready_when_idle", {31'b0, bus.src_ready}, 32'd0);
                if (done) begin
                    done_cnt++;
                    if (exp_done.size() == 0) begin
                        fail_evt("unexpected_done", $sformatf("in=%0d out=%0d", in_count, out_count));
                    end else begin
                        d = exp_done.pop_front();
                        chk("done_in_count", in_count, d.ic);
                        chk("done_out_count", out_count, d.oc);
                        chk("done_error", {31'b0, error}, {31'b0, d.err});
                        chk("done_busy", {31'b0, busy}, 32'd0);
                    end
                end
            end
        end
    end

    // One cycle of stimulus; the source advances when its pixel is taken.
    task automatic step(input logic s, input logic ff, input logic sk);
        @(negedge clk);
        start         = s;
        bus.fifo_full = ff;
        sink_wr_en    = sk;
        bus.src_valid = 1'b1;
        bus.src_data  = pix(tag, idx);
        #1;
        if (bus.src_valid && bus.src_ready) idx++;
    endtask

    task automatic begin_frame(input logic [19:0] eoc, input logic eerr, input logic want_done);
        tag++;
        idx = 0;
        for (int i = 0; i < FP; i++) exp_data.push_back(pix(tag, i));
        if (want_done) exp_done.push_back('{ic: 20'(FP), oc: eoc, err: eerr});
        step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic stream_all(input int budget);
        int n = 0;
        while (idx < FP && n < budget) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        if (idx < FP) fail_evt("stream_bound", $sformatf("only %0d pixels taken", idx));
    endtask

    task automatic sinks(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        if (done_cnt == d0) fail_evt("done_bound", "no done pulse in budget");
        step(1'b0, 1'b0, 1'b0);
        chk("busy_after_done", {31'b0, busy}, 32'd0);
    endtask

    task automatic end_frame(input logic [19:0] eoc);
        chk("end_in_count", in_count, 32'(FP));
        chk("end_out_count", out_count, eoc);
        chk("data_left", exp_data.size(), 32'd0);
    endtask

    task automatic nominal_frame();
        int d0 = done_cnt;
        begin_frame(20'(FP), 1'b0, 1'b1);
        stream_all(40);
        sinks(FP);
        wait_done(d0, 20);
        end_frame(20'(FP));
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        exp_data.delete();
        exp_done.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; sink_wr_en = 1'b0;
        bus.src_valid = 1'b0; bus.src_data = '0; bus.fifo_full = 1'b0;
        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_error", {31'b0, error}, 32'd0);
        chk("rst_ready", {31'b0, bus.src_ready}, 32'd0);
        chk("rst_in_count", in_count, 32'd0);
        chk("rst_out_count", out_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Nominal frame.
        nominal_frame();

        // Backpressure on STREAM cycles 3..7.
        d0 = done_cnt;
        begin_frame(20'(FP), 1'b0, 1'b1);
        for (int c = 1; c <= 60 && idx < FP; c++) begin
            step(1'b0, (c >= 3 && c <= 7), 1'b0);
            if (c >= 3 && c <= 7) begin
                chk("bp_ready", {31'b0, bus.src_ready}, 32'd0);
                chk("bp_wr_en", {31'b0, bus.fifo_wr_en}, 32'd0);
            end
        end
        if (idx < FP) fail_evt("bp_stream_bound", $sformatf("only %0d pixels taken", idx));
        sinks(FP);
        wait_done(d0, 20);
        end_frame(20'(FP));

        // Sink strobes coincident with transfers, plus two extra.
        d0 = done_cnt;
        begin_frame(20'(FP), 1'b0, 1'b1);
        repeat (FP + 2) step(1'b0, 1'b0, 1'b1);
        wait_done(d0, 20);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        chk("ovl_single_done", done_cnt, d0 + 1);
        end_frame(20'(FP));

        // Reset mid-frame at in_count=5.
        begin_frame(20'(FP), 1'b0, 1'b1);
        for (int n = 0; n < 20 && idx < 5; n++) step(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_in_count", in_count, 32'd5);
        rst = 1'b1;
        exp_data.delete();
        exp_done.delete();
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_error", {31'b0, error}, 32'd0);
        chk("mid_rst_ready", {31'b0, bus.src_ready}, 32'd0);
        chk("mid_rst_wr_en", {31'b0, bus.fifo_wr_en}, 32'd0);
        chk("mid_rst_in_count", in_count, 32'd0);
        chk("mid_rst_out_count", out_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step(1'b0, 1'b0, 1'b1);
        chk("post_rst_idle_busy", {31'b0, busy}, 32'd0);
        chk("post_rst_idle_in", in_count, 32'd0);
        chk("post_rst_idle_out", out_count, 32'd0);
        nominal_frame();

        // Start while busy is ignored.
        d0 = done_cnt;
        begin_frame(20'(FP), 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("busy_start_in_count", in_count, 32'd4);
        chk("busy_start_out_count", out_count, 32'd0);
        chk("busy_start_busy", {31'b0, busy}, 32'd1);
        stream_all(40);
        sinks(FP);
        wait_done(d0, 20);
        end_frame(20'(FP));

        // Drain watchdog: only 10 results arrive.
`ifdef FRAME_SEQ_CTRL_TIMEOUT_EN
        d0 = done_cnt;
        begin_frame(20'd10, 1'b1, 1'b1);
        stream_all(40);
        sinks(10);
        wait_done(d0, TO + 10);
        chk("tmo_error_sticky", {31'b0, error}, 32'd1);
        end_frame(20'd10);
        d0 = done_cnt;
        begin_frame(20'(FP), 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("tmo_error_cleared", {31'b0, error}, 32'd0);
        stream_all(40);
        sinks(FP);
        wait_done(d0, 20);
        end_frame(20'(FP));
`else
        d0 = done_cnt;
        begin_frame(20'd10, 1'b0, 1'b0);
        stream_all(40);
        sinks(10);
        repeat (TO + 24) step(1'b0, 1'b0, 1'b0);
        chk("notmo_busy", {31'b0, busy}, 32'd1);
        chk("notmo_error", {31'b0, error}, 32'd0);
        chk("notmo_out_count", out_count, 32'd10);
        chk("notmo_no_done", done_cnt, d0);
        pulse_reset();
        nominal_frame();
`endif

        repeat (3) step(1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_seq_ctrl.md
FRAME_SEQ_CTRL -- requirements
Module: frame_seq_ctrl

Interface
REQ-001 The block SHALL have the parameter IMG_WIDTH, default 720, giving pixels per line.
REQ-002 The block SHALL have the parameter IMG_HEIGHT, default 540, giving lines per frame; FRAME_PIXELS = IMG_WIDTH*IMG_HEIGHT.
REQ-003 The block SHALL have the parameter TIMEOUT_CYCLES, default 4096, giving the drain watchdog limit.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: frame start request, sampled in IDLE only.
REQ-007 The block SHALL have ports src_valid (input, 1), src_data (input, 24, RGB) and src_ready (output, 1): the upstream pixel source handshake.
REQ-008 The block SHALL have ports fifo_wr_en (output, 1), fifo_din (output, 24) and fifo_full (input, 1): write side of the pipeline input FIFO.
REQ-009 The block SHALL have port sink_wr_en, input, 1 bit: pipeline output-write strobe, one pulse per Sobel pixel.
REQ-010 The block SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and error (output, 1, sticky timeout flag).
REQ-011 The block SHALL have ports in_count and out_count, outputs, each 20 bits: pixels accepted and pixels produced in the current frame.

Function
REQ-012 The FSM SHALL have the states IDLE, STREAM, DRAIN and DONE.
REQ-013 In IDLE, start=1 SHALL clear in_count, out_count and error and move to STREAM on the next edge; start in any other state SHALL be ignored.
REQ-014 In STREAM, src_ready SHALL equal !fifo_full, and it SHALL be 0 in every other state.
REQ-015 A transfer (src_valid && src_ready) SHALL assert fifo_wr_en in the same cycle with fifo_din=src_data, with zero latency and combinational pass-through, and SHALL increment in_count.
REQ-016 fifo_wr_en SHALL never be asserted while fifo_full=1 or outside STREAM.
REQ-017 The transfer that makes in_count reach FRAME_PIXELS SHALL move the FSM to DRAIN; no further transfers SHALL occur.
REQ-018 In STREAM and DRAIN, each sink_wr_en SHALL increment out_count, saturating at FRAME_PIXELS; in IDLE and DONE, sink_wr_en SHALL be ignored.
REQ-019 A transfer and a sink_wr_en in the same cycle SHALL update both counters.
REQ-020 When out_count equals FRAME_PIXELS in DRAIN, the FSM SHALL move to DONE.
REQ-021 If out_count reaches FRAME_PIXELS while still in STREAM, the FSM SHALL go through DRAIN for one cycle, then to DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 busy SHALL be 1 in STREAM and DRAIN, and 0 in IDLE and DONE.

Reset
REQ-024 Asserting rst SHALL immediately force IDLE, busy=0, done=0, error=0, src_ready=0, fifo_wr_en=0, in_count=0 and out_count=0, including mid-frame.
REQ-025 After rst is released, the block SHALL do nothing until a new start; downstream FIFOs are reset by the same rst.

Configuration
REQ-026 With FRAME_SEQ_CTRL_TIMEOUT_EN defined, a counter SHALL run in DRAIN, clear on every sink_wr_en, and on reaching TIMEOUT_CYCLES SHALL set error=1 and move to DONE; error SHALL hold until the next accepted start or rst.
REQ-027 Without FRAME_SEQ_CTRL_TIMEOUT_EN, no watchdog logic SHALL exist, error SHALL be tied to 0, and DRAIN SHALL wait indefinitely.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3, FRAME_PIXELS=12, TIMEOUT_CYCLES=16)
REQ-028 Nominal: start pulse, src_valid held high, fifo_full=0, 12 sink_wr_en pulses -> 12 fifo_wr_en with matching data, in_count=12, out_count=12, a single done pulse, busy back to 0.
REQ-029 Backpressure: fifo_full=1 for cycles 3-7 of STREAM -> src_ready=0 and fifo_wr_en=0 in those cycles, no data lost or duplicated, in_count still ends at 12.
REQ-030 Overlap and extra strobes: sink_wr_en coincident with transfers, plus 2 extra pulses after the 12th -> out_count saturates at 12 and exactly one done pulse.
REQ-031 Reset mid-frame: rst asserted at in_count=5 -> all outputs reset that cycle; a new start then runs a clean 12-pixel frame.
REQ-032 Timeout (macro defined): only 10 sink_wr_en pulses, then silence -> 16 cycles later error=1 and a done pulse; the next start clears error. With the macro undefined -> busy stays 1 and error stays 0.
REQ-033 Start while busy: a start pulse in STREAM -> no effect on counters or state.
